operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  decoded instruction valid; accepted only when ready=1.
REQ-004 two_op  input  1  1=format I (src+dst), 0=format II (single operand, dst phases skipped).
REQ-005 As  input  2  source mode: 00 Rn, 01 X(Rn), 10 @Rn, 11 @Rn+.
REQ-006 Ad  input  1  dest mode: 0 Rn, 1 X(Rn).
REQ-007 src_reg  input  4  source register number (constant-generator decode only).
REQ-008 bw  input  1  1=byte op; autoincrement step 1, else 2.
REQ-009 mem_rdy  input  1  memory completes current read this cycle.
REQ-010 exec_ready  input  1  execute stage consumes operands this cycle.
REQ-011 ready  output  1  high in IDLE only.
REQ-012 mem_rd, ext_fetch  output  1 each  memory read request; ext_fetch=1 means MAB from PC.
REQ-013 srcM, srcL, dstM, dstL, AddrL, IdxM  output  1 each  operand-fetch controls.
REQ-014 AddrM  output  2  MAB select: 0 latched addr, 2 Rsrc, 3 Rdst.
REQ-015 pc_inc  output  1  PC += 2 pulse after extension word.
REQ-016 src_inc  output  1  Rsrc += inc_step pulse; inc_step output 2 = bw ? 1 : 2.
REQ-017 exec_valid  output  1  operands valid for execute stage.
REQ-018 cg_sel  output  1  source is constant generator (CG_EN only, else tied 0).

Function
REQ-019 States SHALL be IDLE, SRC_EXT, SRC_RD, DST_EXT, DST_RD, EXEC, binary-encoded.
REQ-020 IDLE+start: As=01->SRC_EXT; As=1x->SRC_RD; else two_op&Ad->DST_EXT; else EXEC.
REQ-021 SRC_EXT: mem_rd=1, ext_fetch=1; on mem_rdy pulse AddrL=1, AddrM=0, IdxM=0, pc_inc=1, go SRC_RD.
REQ-022 SRC_RD: mem_rd=1, AddrM=0 if As=01 else 2; on mem_rdy pulse srcL=1, plus src_inc=1 if As=11; then DST_EXT if two_op&Ad else EXEC.
REQ-023 DST_EXT: mem_rd=1, ext_fetch=1; on mem_rdy pulse AddrL=1, AddrM=0, IdxM=1, pc_inc=1, go DST_RD.
REQ-024 DST_RD: mem_rd=1, AddrM=0, dstM=1; on mem_rdy pulse dstL=1, go EXEC.
REQ-025 EXEC: exec_valid=1; srcM=1 iff As!=00 latched; dstM=1 iff two_op&Ad latched; held until exec_ready, then IDLE.
REQ-026 mode fields SHALL be latched at start acceptance; later input changes ignored until IDLE.
REQ-027 mem_rdy low SHALL stall the state with mem_rd/ext_fetch/AddrM held and all latch/inc pulses 0.
REQ-028 start while ready=0 SHALL be ignored, no queuing.
REQ-029 all pulse outputs SHALL be combinational from state and mem_rdy/exec_ready, one cycle each.
REQ-030 @PC+ (immediate) is As=11 with src_reg=0, identical sequence; no special case.

Reset
REQ-031 rst SHALL force IDLE, ready=1, all other outputs 0, latched modes 0, next edge, including mid-sequence.

Configuration
REQ-032 OPSEQ_CG_EN defined: src_reg=3 (any As) or src_reg=2 with As=1x SHALL skip source phases, assert cg_sel from start to EXEC exit, srcM=0 in EXEC.
REQ-033 OPSEQ_CG_EN undefined: cg_sel tied 0; these encodings follow REQ-020..REQ-025 unchanged.

Structure
REQ-034 state encoding, addressing-mode constants (AS_REG, AS_IDX, AS_IND, AS_INC), AddrM select codes SHALL live in shared package msp_cpu_pkg.
REQ-035 one sub-module, opseq_decode (combinational next-state/output decode), SHALL be instantiated; registers in top.

Verification
REQ-036 As=00, Ad=0, two_op=1, exec_ready=1 -> IDLE,EXEC,IDLE; exec_valid 1 cycle; no mem_rd.
REQ-037 As=01, Ad=1, mem_rdy=1 always -> 4 read cycles, pc_inc twice, IdxM 0 then 1, srcM=dstM=1 in EXEC.
REQ-038 As=11, bw=1, src_reg=4, mem_rdy low 3 cycles in SRC_RD -> stall 3 cycles, then srcL+src_inc, inc_step=1.
REQ-039 rst asserted in DST_RD -> next cycle IDLE, ready=1, all pulses 0; new start accepted.
REQ-040 OPSEQ_CG_EN, src_reg=3, As=10, Ad=0 -> IDLE to EXEC directly, cg_sel=1, no mem_rd; undefined -> SRC_RD taken.
REQ-041 exec_ready low 5 cycles in EXEC, start pulsed -> exec_valid held 5 cycles, start ignored.

Source files
------------

// File: rtl/msp_cpu_pkg.sv
// Shared CPU definitions: operand-sequencer state encoding, addressing-mode
// constants, MAB select codes and the constant-generator decode helper.
package msp_cpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SRC_EXT = 3'd1,
        SRC_RD  = 3'd2,
        DST_EXT = 3'd3,
        DST_RD  = 3'd4,
        EXEC    = 3'd5
    } opseq_state_e;

    localparam logic [1:0] AS_REG = 2'b00;
    localparam logic [1:0] AS_IDX = 2'b01;
    localparam logic [1:0] AS_IND = 2'b10;
    localparam logic [1:0] AS_INC = 2'b11;

    localparam logic [1:0] ADDRM_LATCH = 2'd0;
    localparam logic [1:0] ADDRM_RSRC  = 2'd2;
    localparam logic [1:0] ADDRM_RDST  = 2'd3;

    // R3 in any mode and R2 in indirect modes yield constants, not memory operands.
    function automatic logic is_cg(input logic [3:0] src_reg, input logic [1:0] as_mode);
        return (src_reg == 4'd3) || (src_reg == 4'd2 && as_mode[1]);
    endfunction

endpackage

// File: rtl/opseq_decode.sv
// Combinational next-state and output decode for the operand sequencer.
// Constant-generator bypass is enabled by defining OPSEQ_CG_EN.
module opseq_decode
    import msp_cpu_pkg::*;
(
    input  opseq_state_e state,
    input  logic         start,
    input  logic         two_op,
    input  logic [1:0]   as_in,
    input  logic         ad_in,
    input  logic [3:0]   src_reg,
    input  logic [1:0]   as_q,
    input  logic         ad_q,
    input  logic         two_op_q,
    input  logic         bw_q,
    input  logic         cg_q,
    input  logic         mem_rdy,
    input  logic         exec_ready,
    output opseq_state_e next_state,
    output logic         cg_hit,
    output logic         ready,
    output logic         mem_rd,
    output logic         ext_fetch,
    output logic         src_m,
    output logic         src_l,
    output logic         dst_m,
    output logic         dst_l,
    output logic         addr_l,
    output logic         idx_m,
    output logic [1:0]   addr_m,
    output logic         pc_inc,
    output logic         src_inc,
    output logic [1:0]   inc_step,
    output logic         exec_valid,
    output logic         cg_sel
);

`ifdef OPSEQ_CG_EN
    assign cg_hit = is_cg(src_reg, as_in);
`else
    logic unused_src_reg;
    assign unused_src_reg = ^src_reg;
    assign cg_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        mem_rd     = 1'b0;
        ext_fetch  = 1'b0;
        src_m      = 1'b0;
        src_l      = 1'b0;
        dst_m      = 1'b0;
        dst_l      = 1'b0;
        addr_l     = 1'b0;
        idx_m      = 1'b0;
        addr_m     = ADDRM_LATCH;
        pc_inc     = 1'b0;
        src_inc    = 1'b0;
        exec_valid = 1'b0;
        inc_step   = (state == IDLE) ? 2'd0 : (bw_q ? 2'd1 : 2'd2);
        cg_sel     = (state != IDLE) && cg_q;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (!cg_hit && as_in == AS_IDX)  next_state = SRC_EXT;
                    else if (!cg_hit && as_in[1])    next_state = SRC_RD;
                    else if (two_op && ad_in)        next_state = DST_EXT;
                    else                             next_state = EXEC;
                end
            end
            SRC_EXT: begin
                mem_rd    = 1'b1;
                ext_fetch = 1'b1;
                if (mem_rdy) begin
                    addr_l     = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = SRC_RD;
                end
            end
            SRC_RD: begin
                mem_rd = 1'b1;
                addr_m = (as_q == AS_IDX) ? ADDRM_LATCH : ADDRM_RSRC;
                if (mem_rdy) begin
                    src_l      = 1'b1;
                    src_inc    = (as_q == AS_INC);
                    next_state = (two_op_q && ad_q) ? DST_EXT : EXEC;
                end
            end
            DST_EXT: begin
                mem_rd    = 1'b1;
                ext_fetch = 1'b1;
                if (mem_rdy) begin
                    addr_l     = 1'b1;
                    idx_m      = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = DST_RD;
                end
            end
            DST_RD: begin
                mem_rd = 1'b1;
                dst_m  = 1'b1;
                if (mem_rdy) begin
                    dst_l      = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                exec_valid = 1'b1;
                src_m      = (as_q != AS_REG) && !cg_q;
                dst_m      = two_op_q && ad_q;
                if (exec_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/operand_sequencer.sv
// Operand-fetch sequencer: state and latched instruction-mode registers around
// the combinational opseq_decode. OPSEQ_CG_EN selects the constant-generator bypass.
module operand_sequencer
    import msp_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       two_op,
    input  logic [1:0] As,
    input  logic       Ad,
    input  logic [3:0] src_reg,
    input  logic       bw,
    input  logic       mem_rdy,
    input  logic       exec_ready,
    output logic       ready,
    output logic       mem_rd,
    output logic       ext_fetch,
    output logic       srcM,
    output logic       srcL,
    output logic       dstM,
    output logic       dstL,
    output logic       AddrL,
    output logic       IdxM,
    output logic [1:0] AddrM,
    output logic       pc_inc,
    output logic       src_inc,
    output logic [1:0] inc_step,
    output logic       exec_valid,
    output logic       cg_sel
);

    opseq_state_e state, next_state;
    logic [1:0]   as_q;
    logic         ad_q, two_op_q, bw_q, cg_q, cg_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            as_q     <= '0;
            ad_q     <= 1'b0;
            two_op_q <= 1'b0;
            bw_q     <= 1'b0;
            cg_q     <= 1'b0;
        end else begin
            state <= next_state;
            // Modes are captured only on acceptance and frozen until IDLE again.
            if (state == IDLE && start) begin
                as_q     <= As;
                ad_q     <= Ad;
                two_op_q <= two_op;
                bw_q     <= bw;
                cg_q     <= cg_hit;
            end
        end
    end

    opseq_decode u_decode (
        .state      (state),
        .start      (start),
        .two_op     (two_op),
        .as_in      (As),
        .ad_in      (Ad),
        .src_reg    (src_reg),
        .as_q       (as_q),
        .ad_q       (ad_q),
        .two_op_q   (two_op_q),
        .bw_q       (bw_q),
        .cg_q       (cg_q),
        .mem_rdy    (mem_rdy),
        .exec_ready (exec_ready),
        .next_state (next_state),
        .cg_hit     (cg_hit),
        .ready      (ready),
        .mem_rd     (mem_rd),
        .ext_fetch  (ext_fetch),
        .src_m      (srcM),
        .src_l      (srcL),
        .dst_m      (dstM),
        .dst_l      (dstL),
        .addr_l     (AddrL),
        .idx_m      (IdxM),
        .addr_m     (AddrM),
        .pc_inc     (pc_inc),
        .src_inc    (src_inc),
        .inc_step   (inc_step),
        .exec_valid (exec_valid),
        .cg_sel     (cg_sel)
    );

endmodule

// File: tb/tb_operand_sequencer.sv
// Operand sequencer bench: phase-list reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, two_op, Ad, bw, mem_rdy, exec_ready;
    logic [1:0] As;
    logic [3:0] src_reg;
    logic       ready, mem_rd, ext_fetch, srcM, srcL, dstM, dstL, AddrL, IdxM;
    logic       pc_inc, src_inc, exec_valid, cg_sel;
    logic [1:0] AddrM, inc_step;

    operand_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .two_op(two_op), .As(As), .Ad(Ad),
        .src_reg(src_reg), .bw(bw), .mem_rdy(mem_rdy), .exec_ready(exec_ready),
        .ready(ready), .mem_rd(mem_rd), .ext_fetch(ext_fetch), .srcM(srcM),
        .srcL(srcL), .dstM(dstM), .dstL(dstL), .AddrL(AddrL), .IdxM(IdxM),
        .AddrM(AddrM), .pc_inc(pc_inc), .src_inc(src_inc), .inc_step(inc_step),
        .exec_valid(exec_valid), .cg_sel(cg_sel)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: pending list of operand phases for the accepted instruction.
    localparam int P_SEXT = 1, P_SRD = 2, P_DEXT = 3, P_DRD = 4, P_EXEC = 5;
    int         phases[$];
    logic [1:0] m_as;
    logic       m_ad, m_two, m_bw, m_cg;

    // Per-scenario observation counters
    int n_memrd, n_pcinc, n_exec, n_idxm, n_addrl, n_sd_exec, n_srcl, n_inc1;

    function automatic logic model_cg(input logic [3:0] r, input logic [1:0] a);
`ifdef OPSEQ_CG_EN
        return (r == 4'd3) || (r == 4'd2 && a >= 2'd2);
`else
        return 1'b0;
`endif
    endfunction

    // Packed order: ready mem_rd ext srcM srcL dstM dstL AddrL IdxM AddrM pc_inc src_inc inc_step exec_valid cg_sel
    function automatic logic [16:0] expected();
        logic r = 0, mr = 0, ex = 0, sm = 0, sl = 0, dm = 0, dl = 0, al = 0, im = 0;
        logic pi = 0, si = 0, ev = 0, cg = 0;
        logic [1:0] am = 0, is = 0;
        if (phases.size() == 0) begin
            r = 1;
        end else begin
            cg = m_cg;
            is = m_bw ? 2'd1 : 2'd2;
            case (phases[0])
                P_SEXT: begin mr = 1; ex = 1; al = mem_rdy; pi = mem_rdy; end
                P_SRD: begin
                    mr = 1; am = (m_as == 2'd1) ? 2'd0 : 2'd2;
                    sl = mem_rdy; si = mem_rdy && (m_as == 2'd3);
                end
                P_DEXT: begin mr = 1; ex = 1; al = mem_rdy; im = mem_rdy; pi = mem_rdy; end
                P_DRD:  begin mr = 1; dm = 1; dl = mem_rdy; end
                default: begin ev = 1; sm = (m_as != 0) && !m_cg; dm = m_two && m_ad; end
            endcase
        end
        return {r, mr, ex, sm, sl, dm, dl, al, im, am, pi, si, is, ev, cg};
    endfunction

    function automatic logic [16:0] observed();
        return {ready, mem_rd, ext_fetch, srcM, srcL, dstM, dstL, AddrL, IdxM, AddrM,
                pc_inc, src_inc, inc_step, exec_valid, cg_sel};
    endfunction

    task automatic model_clock();
        if (rst) begin
            phases.delete();
            m_as = 0; m_ad = 0; m_two = 0; m_bw = 0; m_cg = 0;
        end else if (phases.size() == 0) begin
            if (start) begin
                m_as = As; m_ad = Ad; m_two = two_op; m_bw = bw; m_cg = model_cg(src_reg, As);
                if (!m_cg && As == 2'd1) begin phases.push_back(P_SEXT); phases.push_back(P_SRD); end
                if (!m_cg && As >= 2'd2) phases.push_back(P_SRD);
                if (two_op && Ad) begin phases.push_back(P_DEXT); phases.push_back(P_DRD); end
                phases.push_back(P_EXEC);
            end
        end else if (phases[0] == P_EXEC) begin
            if (exec_ready) void'(phases.pop_front());
        end else if (mem_rdy) begin
            void'(phases.pop_front());
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_memrd = 0; n_pcinc = 0; n_exec = 0; n_idxm = 0;
        n_addrl = 0; n_sd_exec = 0; n_srcl = 0; n_inc1 = 0;
    endtask

    // Caller has driven inputs just after a negedge; compare, then advance one cycle.
    task automatic step();
        logic [16:0] e, o;
        #1;
        e = expected();
        o = observed();
        vectors++;
        if (e !== o) begin
            miscompares++;
            $display("FAIL cycle_outputs @%0t: got %b, expected %b", $time, o, e);
        end
        n_memrd   += int'(mem_rd);
        n_pcinc   += int'(pc_inc);
        n_exec    += int'(exec_valid);
        n_idxm    += int'(IdxM);
        n_addrl   += int'(AddrL);
        n_sd_exec += int'(exec_valid && srcM && dstM);
        n_srcl    += int'(srcL);
        n_inc1    += int'(srcL && src_inc && inc_step == 2'd1);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [1:0] a, input logic d, input logic t,
                             input logic b, input logic [3:0] r);
        As = a; Ad = d; two_op = t; bw = b; src_reg = r;
    endtask

    initial begin
        rst = 1; start = 0; mem_rdy = 1; exec_ready = 1;
        set_instr(2'd0, 0, 0, 0, 4'd4);
        phases.delete();
        m_as = 0; m_ad = 0; m_two = 0; m_bw = 0; m_cg = 0;
        @(negedge clk);
        step();
        rst = 0;
        check("reset_ready", int'(ready), 1);
        check("reset_outputs", int'(observed()), 17'h10000);

        // Register-mode instruction: IDLE, EXEC, IDLE with no memory traffic
        clear_counts();
        set_instr(2'd0, 0, 1, 0, 4'd4); start = 1; step();
        start = 0; step(); step();
        check("reg_memrd", n_memrd, 0);
        check("reg_exec_cycles", n_exec, 1);
        check("reg_back_idle", int'(ready), 1);

        // Indexed source and destination: four reads, two extension words
        clear_counts();
        set_instr(2'd1, 1, 1, 0, 4'd5); start = 1; step();
        start = 0; repeat (6) step();
        check("idx_memrd", n_memrd, 4);
        check("idx_pcinc", n_pcinc, 2);
        check("idx_addrl", n_addrl, 2);
        check("idx_idxm", n_idxm, 1);
        check("idx_src_dst_exec", n_sd_exec, 1);

        // Byte autoincrement with three-cycle memory stall
        clear_counts();
        set_instr(2'd3, 0, 0, 1, 4'd4); start = 1; step();
        start = 0; mem_rdy = 0; repeat (3) step();
        check("stall_srcl", n_srcl, 0);
        check("stall_memrd", n_memrd, 3);
        mem_rdy = 1; step();
        check("inc_pulse_step1", n_inc1, 1);
        step();
        check("inc_back_idle", int'(ready), 1);

        // Reset mid-sequence in DST_RD, then a fresh start is accepted
        set_instr(2'd1, 1, 1, 0, 4'd6); start = 1; step();
        start = 0; repeat (3) step();
        check("in_dst_rd", int'(dstM && mem_rd), 1);
        rst = 1; step(); rst = 0;
        check("rst_ready", int'(ready), 1);
        check("rst_outputs", int'(observed()), 17'h10000);
        set_instr(2'd0, 0, 0, 0, 4'd4); start = 1; step(); start = 0;
        check("restart_exec", int'(exec_valid), 1);
        step();

        // Constant generator source R3, indirect mode
        set_instr(2'd2, 0, 1, 0, 4'd3); start = 1; step(); start = 0;
`ifdef OPSEQ_CG_EN
        check("cg_direct_exec", int'(exec_valid && cg_sel && !mem_rd && !srcM), 1);
        step();
`else
        check("cg_off_src_rd", int'(mem_rd && AddrM == 2'd2 && !cg_sel), 1);
        step(); step();
`endif

        // Execute back-pressure: start pulses ignored while busy
        clear_counts();
        set_instr(2'd0, 0, 1, 0, 4'd4); start = 1; step();
        exec_ready = 0;
        for (int i = 0; i < 5; i++) begin start = i[0]; step(); end
        check("exec_hold_cycles", n_exec, 5);
        start = 0; exec_ready = 1; step();
        check("exec_release_idle", int'(ready), 1);
        step();
        check("no_queued_start", int'(ready && !exec_valid), 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(63) == 0);
            start      = $urandom_range(1);
            mem_rdy    = ($urandom_range(9) < 7);
            exec_ready = ($urandom_range(9) < 6);
            set_instr(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), 4'($urandom_range(15)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
